riscv_mem_unit: RTL and testbench
=================================

# riscv_mem_unit

Unified instruction/data memory for the multi-cycle RISC-V core, sitting directly downstream of the core's fetch and load/store states. It accepts one request at a time over a valid/ready handshake and applies byte/half/word write masking. It returns sign- or zero-extended read data after a configurable fixed latency, and flags misaligned or out-of-range accesses. Storage is a word array named `mem`, so benches preload programs hierarchically.

## Interface
- `DEPTH`, 1024: number of 32-bit words in `mem`.
- `ADDR_W`, 10: word-index width; `DEPTH` ≤ 2^`ADDR_W`.
- `LATENCY`, 2: cycles from request accept to response; legal range 1..15.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block can accept a request this cycle.
- `req_we`  in  1: 1 = store, 0 = load/fetch.
- `req_addr`  in  32: byte address.
- `req_size`  in  2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_unsigned`  in  1: zero-extend byte/half loads (LBU/LHU); ignored for word.
- `req_wdata`  in  32: store data, right-aligned (bits [7:0] byte, [15:0] half).
- `resp_valid`  out  1: one-cycle pulse; response fields valid.
- `resp_rdata`  out  32: extended load data; 0 for stores and errors.
- `resp_err`  out  1: misaligned or out-of-range access.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. A handshake (`req_valid`&&`req_ready`) at an edge latches we/addr/size/unsigned/wdata.
  - Next state is WAIT with `cnt`=`LATENCY`-2 when `LATENCY`≥2.
  - Next state is RESP directly when `LATENCY`=1.
- WAIT: `req_ready`=0. Decrement `cnt` each cycle. Leave for RESP at the edge where `cnt`==0.
- Access commit happens at the edge entering RESP. The store writes `mem` and the load captures `resp_rdata`.
- RESP: `resp_valid`=1 for exactly one cycle, `req_ready`=0. Next state is IDLE.
- Word index is `addr[ADDR_W+1:2]`. Out of range when `addr[31:2]` ≥ `DEPTH`.
- Misaligned when:
  - half with `addr[0]`=1, or
  - word with `addr[1:0]`≠0.
- Error behaviour: `mem` is unchanged, `resp_rdata`=0, `resp_err`=1.
- Store lanes:
  - byte writes lane `addr[1:0]` with `wdata[7:0]`;
  - half writes lanes {`addr[1]`,0} and {`addr[1]`,1} with `wdata[15:0]`;
  - word writes all lanes.
  - Unselected lanes keep their value.
- Load extract:
  - byte takes lane `addr[1:0]`, half takes the half at `addr[1]`.
  - Sign-extend unless `req_unsigned`=1.
  - Word returns the full word.
- Stores return `resp_rdata`=0, `resp_err`=0 on success.
- `req_valid` while `req_ready`=0 is ignored. The requester holds it until accepted, and the block does not queue requests.
- Request inputs are sampled only at the accept edge. Changes afterwards do not affect the in-flight access.

## Timing
- Reset values:
  - state=IDLE, `cnt`=0;
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0;
  - `req_ready`=0 while `reset` is high and 1 in the first cycle after release.
- `mem` contents are not cleared by reset.
- Latency: accept at edge t gives `resp_valid` high in the cycle after edge t+`LATENCY`-1, sampled by the consumer at edge t+`LATENCY`.
- Throughput: one request per `LATENCY`+1 cycles. `req_ready` returns the cycle after the RESP cycle.
- `resp_rdata`/`resp_err` hold their values after the RESP cycle until the next commit.
- Reset mid-operation (WAIT or RESP): abort immediately.
  - An uncommitted store does not write.
  - `resp_valid` is 0 from the next cycle.
- Reset and `req_valid` asserted together: no accept.
- A store followed by a load of the same address returns the new data, because the commit precedes the next accept.

## Test plan
- Reset, preload `mem[0]`=32'h00200093, load word at addr 0 with `LATENCY`=2 -> `resp_valid` exactly 2 cycles after accept, `resp_rdata`=32'h00200093, `resp_err`=0.
- Store byte 8'h80 at addr 0x13, then load signed byte 0x13 and unsigned byte 0x13 -> rdata 32'hFFFFFF80 then 32'h00000080. Lanes 0..2 of `mem[4]` are unchanged.
- Store half 16'hBEEF at 0x22 over `mem[8]`=32'h11223344, then load word 0x20 -> 32'hBEEF3344. Signed half load at 0x22 -> 32'hFFFFBEEF.
- Word load at 0x6, half store at 0x5, and word load at `DEPTH`*4 -> each gives `resp_err`=1 and rdata 0; a word reread of 0x4 shows memory unchanged.
- Hold `req_valid`=1 continuously with `LATENCY`=1 -> `req_ready` pattern 1,0,1,0; exactly one `resp_valid` per accept; no double accepts.
- Accept a store to 0x40 (old value 32'hAAAAAAAA), assert `reset` during WAIT (`LATENCY`=3) -> no `resp_valid`; word 0x40 still reads 32'hAAAAAAAA after reset release.

Source files
------------

// File: rtl/riscv_mem_unit.sv
// riscv_mem_unit: unified instruction/data memory for the multi-cycle core.
// One request at a time over valid/ready, fixed response latency, byte/half/word
// store masking, sign/zero-extended loads, misaligned/out-of-range error flag.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_we, req_addr, req_size,     request fields (sampled at the accept edge)
//   req_unsigned, req_wdata
//   resp_valid                      one-cycle response pulse
//   resp_rdata, resp_err            response data / error (held until next commit)
module riscv_mem_unit #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              accept;
  logic              ready_d, valid_d, commit;

  // Request fields captured at accept
  logic              lat_we;
  logic [31:0]       lat_addr;
  logic [1:0]        lat_size;
  logic              lat_uns;
  logic [31:0]       lat_wdata;

  // Fields used by the commit; with LATENCY=1 the commit is the accept edge itself
  logic              eff_we;
  logic [31:0]       eff_addr;
  logic [1:0]        eff_size;
  logic              eff_uns;
  logic [31:0]       eff_wdata;

  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic              out_of_range, misaligned, acc_err;
  logic [3:0]        wmask;
  logic [31:0]       wdata_al;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_data;

  assign accept = req_valid && req_ready && !reset;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    cnt_d      = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            next_state = RESP;
          end else begin
            next_state = WAIT;
            cnt_d      = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) next_state = RESP;
        else           cnt_d      = cnt - CNT_W'(1);
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic (next values of the registered outputs, commit strobe)
  always_comb begin
    ready_d = 1'b0;
    valid_d = 1'b0;
    commit  = 1'b0;
    if (!reset) begin
      ready_d = (next_state == IDLE);
      valid_d = (next_state == RESP);
      commit  = (next_state == RESP);
    end
  end

  // Capture request fields at accept
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_size  <= req_size;
      lat_uns   <= req_unsigned;
      lat_wdata <= req_wdata;
    end
  end

  // Access decode
  always_comb begin
    if (state == IDLE) begin
      eff_we    = req_we;
      eff_addr  = req_addr;
      eff_size  = req_size;
      eff_uns   = req_unsigned;
      eff_wdata = req_wdata;
    end else begin
      eff_we    = lat_we;
      eff_addr  = lat_addr;
      eff_size  = lat_size;
      eff_uns   = lat_uns;
      eff_wdata = lat_wdata;
    end

    idx          = eff_addr[ADDR_W+1:2];
    out_of_range = (eff_addr[31:2] >= 30'(DEPTH));
    misaligned   = 1'b0;
    wmask        = 4'b1111;
    wdata_al     = eff_wdata;
    case (eff_size)
      2'b00: begin
        wmask    = 4'b0001 << eff_addr[1:0];
        wdata_al = {4{eff_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = eff_addr[0];
        wmask      = eff_addr[1] ? 4'b1100 : 4'b0011;
        wdata_al   = {2{eff_wdata[15:0]}};
      end
      default: misaligned = (eff_addr[1:0] != 2'b00);
    endcase
    acc_err = out_of_range || misaligned;

    rd_word = mem[idx];
    rd_byte = rd_word[{eff_addr[1:0], 3'b000} +: 8];
    rd_half = eff_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (eff_size)
      2'b00:   load_data = eff_uns ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_data = eff_uns ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase
  end

  // Storage: masked lane writes at commit; never cleared by reset
  always_ff @(posedge clk) begin
    if (commit && eff_we && !acc_err) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (wmask[lane]) mem[idx][lane*8 +: 8] <= wdata_al[lane*8 +: 8];
      end
    end
  end

  // Registered response and ready
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      req_ready  <= ready_d;
      resp_valid <= valid_d;
      if (commit) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_err || eff_we) ? 32'd0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_unit.sv
// Self-checking bench for riscv_mem_unit: three instances (LATENCY 2, 1, 3),
// directed scenarios plus randomized traffic checked against a byte-addressed model.
module tb_riscv_mem_unit;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset        [3];
  logic        req_valid    [3];
  logic        req_ready    [3];
  logic        req_we       [3];
  logic [31:0] req_addr     [3];
  logic [1:0]  req_size     [3];
  logic        req_unsigned [3];
  logic [31:0] req_wdata    [3];
  logic        resp_valid   [3];
  logic [31:0] resp_rdata   [3];
  logic        resp_err     [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int unsigned LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 3);
      riscv_mem_unit #(.DEPTH(DEPTH), .ADDR_W(10), .LATENCY(LAT)) u_dut (
        .clk          (clk),
        .reset        (reset[gi]),
        .req_valid    (req_valid[gi]),
        .req_ready    (req_ready[gi]),
        .req_we       (req_we[gi]),
        .req_addr     (req_addr[gi]),
        .req_size     (req_size[gi]),
        .req_unsigned (req_unsigned[gi]),
        .req_wdata    (req_wdata[gi]),
        .resp_valid   (resp_valid[gi]),
        .resp_rdata   (resp_rdata[gi]),
        .resp_err     (resp_err[gi])
      );
    end
  endgenerate

  int n_cmp = 0;
  int n_bad = 0;

  // Reference memory for instance 0, one entry per byte address
  byte unsigned mb [int unsigned];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_op(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic err);
    int unsigned nb;
    logic [31:0] v;
    nb  = (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
    err = ((addr % nb) != 0) || ((addr >> 2) >= DEPTH);
    rd  = 32'd0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < int'(nb); k++) mb[addr + 32'(k)] = wdata[8*k +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < int'(nb); k++) v = v | (32'(mb[addr + 32'(k)]) << (8*k));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
        rd = v;
      end
    end
  endtask

  // One complete transaction on instance u; instance 0 is also checked against the model
  task automatic op(input int u, input logic we, input logic [31:0] addr, input logic [1:0] size,
                    input logic uns, input logic [31:0] wdata,
                    output logic [31:0] rd, output logic err);
    int n;
    int lat;
    logic [31:0] mrd;
    logic        merr;
    lat = (u == 0) ? 2 : ((u == 1) ? 1 : 3);
    @(negedge clk);
    req_valid[u]    = 1'b1;
    req_we[u]       = we;
    req_addr[u]     = addr;
    req_size[u]     = size;
    req_unsigned[u] = uns;
    req_wdata[u]    = wdata;
    n = 0;
    while (!req_ready[u] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[u]) check("accept_timeout", 32'(req_ready[u]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Scramble the request lines after accept; the in-flight access must not notice
    req_valid[u]    = 1'b0;
    req_we[u]       = 1'($urandom);
    req_addr[u]     = $urandom;
    req_size[u]     = 2'($urandom);
    req_unsigned[u] = 1'($urandom);
    req_wdata[u]    = $urandom;
    n = 0;
    while (!resp_valid[u] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("resp_latency", 32'(n), 32'(lat - 1));
    rd  = resp_rdata[u];
    err = resp_err[u];
    @(negedge clk);
    check("resp_pulse", 32'(resp_valid[u]), 32'd0);
    check("ready_back", 32'(req_ready[u]), 32'd1);
    if (u == 0) begin
      model_op(we, addr, size, uns, wdata, mrd, merr);
      check("model_rdata", rd, mrd);
      check("model_err", 32'(err), 32'(merr));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [31:0] a;

    for (int u = 0; u < 3; u++) begin
      reset[u]        = 1'b1;
      req_valid[u]    = 1'b0;
      req_we[u]       = 1'b0;
      req_addr[u]     = 32'd0;
      req_size[u]     = 2'd0;
      req_unsigned[u] = 1'b0;
      req_wdata[u]    = 32'd0;
    end
    // Instance 1 holds a word store to 0 from reset onward
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_size[1]  = 2'd2;
    req_wdata[1] = 32'h0000_0055;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready[0]), 32'd0);
    check("rst_valid", 32'(resp_valid[0]), 32'd0);
    check("rst_rdata", resp_rdata[0], 32'd0);
    check("rst_err", 32'(resp_err[0]), 32'd0);
    check("rst_valid_held_req", 32'(resp_valid[1]), 32'd0);
    check("rst_ready_held_req", 32'(req_ready[1]), 32'd0);
    reset[0] = 1'b0;
    reset[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_release", 32'(req_ready[0]), 32'd1);

    // Program word at 0, then fetch it back
    op(0, 1'b1, 32'h0, 2'd2, 1'b0, 32'h0020_0093, rd, err);
    check("store_rdata_zero", rd, 32'd0);
    op(0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, rd, err);
    check("fetch_word0", rd, 32'h0020_0093);
    check("fetch_err0", 32'(err), 32'd0);

    // Fill words 1..63 with random data
    for (int w = 1; w < 64; w++) op(0, 1'b1, 32'(w * 4), 2'd2, 1'b0, $urandom, rd, err);

    // Byte store / signed and unsigned byte loads
    op(0, 1'b1, 32'h13, 2'd0, 1'b0, 32'hABCD_EF80, rd, err);
    op(0, 1'b0, 32'h13, 2'd0, 1'b0, 32'h0, rd, err);
    check("lb_signed", rd, 32'hFFFF_FF80);
    op(0, 1'b0, 32'h13, 2'd0, 1'b1, 32'h0, rd, err);
    check("lbu", rd, 32'h0000_0080);
    op(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, rd, err);

    // Half store over a known word
    op(0, 1'b1, 32'h20, 2'd2, 1'b0, 32'h1122_3344, rd, err);
    op(0, 1'b1, 32'h22, 2'd1, 1'b0, 32'h7777_BEEF, rd, err);
    op(0, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, rd, err);
    check("sh_word", rd, 32'hBEEF_3344);
    op(0, 1'b0, 32'h22, 2'd1, 1'b0, 32'h0, rd, err);
    check("lh_signed", rd, 32'hFFFF_BEEF);

    // Error cases
    op(0, 1'b0, 32'h6, 2'd2, 1'b0, 32'h0, rd, err);
    check("lw_misal_err", 32'(err), 32'd1);
    check("lw_misal_rdata", rd, 32'd0);
    op(0, 1'b1, 32'h5, 2'd1, 1'b0, 32'hDEAD_BEEF, rd, err);
    check("sh_misal_err", 32'(err), 32'd1);
    op(0, 1'b0, 32'(DEPTH * 4), 2'd2, 1'b0, 32'h0, rd, err);
    check("lw_oor_err", 32'(err), 32'd1);
    check("lw_oor_rdata", rd, 32'd0);
    op(0, 1'b0, 32'h4, 2'd2, 1'b0, 32'h0, rd, err);

    // Randomized traffic against the model
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 9) == 0) a = 32'(DEPTH * 4) + $urandom_range(0, 32'hFFFF);
      else                           a = $urandom_range(0, 255);
      op(0, 1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, rd, err);
    end

    // LATENCY=1 with req_valid held: ready alternates, one response per accept
    @(negedge clk);
    reset[1] = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("l1_ready_pattern", 32'(req_ready[1]), 32'((i % 2) == 0));
      check("l1_valid_pattern", 32'(resp_valid[1]), 32'((i % 2) == 1));
    end
    req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("l1_no_extra_resp", 32'(resp_valid[1]), 32'd0);
    op(1, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, rd, err);
    check("l1_readback", rd, 32'h0000_0055);

    // LATENCY=3: reset during WAIT aborts the store
    op(2, 1'b1, 32'h40, 2'd2, 1'b0, 32'hAAAA_AAAA, rd, err);
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 32'h40;
    req_size[2]  = 2'd2;
    req_wdata[2] = 32'h1234_5678;
    check("l3_ready_before", 32'(req_ready[2]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    reset[2]     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("l3_abort_valid", 32'(resp_valid[2]), 32'd0);
      check("l3_abort_ready", 32'(req_ready[2]), 32'd0);
    end
    reset[2] = 1'b0;
    @(posedge clk);
    op(2, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, rd, err);
    check("l3_mem_kept", rd, 32'hAAAA_AAAA);
    check("l3_err", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
